// File: rtl/pdp8_tty_pkg.sv
// pdp8_tty_pkg: shared types and constants for the console TTY receive/transmit blocks.
// Rev 1.0
`default_nettype none

package pdp8_tty_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;

   // Clocks per oversample tick, rounded to nearest, never below 1.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + 8 * baud) / (16 * baud);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tty_rx_buffer_if.sv
// tty_rx_buffer_if: serial input plus keyboard IOT pop/flag side of the receive buffer.
// Rev 1.0
`default_nettype none

interface tty_rx_buffer_if;
   logic       rx;
   logic       clear;
   logic       pop;
   logic [7:0] data;
   logic       avail;
   logic       irq;
   logic [4:0] count;
   logic       overrun;
   logic       frame_err;

   modport slave (
      input  rx, clear, pop,
      output data, avail, irq, count, overrun, frame_err
   );

   modport master (
      output rx, clear, pop,
      input  data, avail, irq, count, overrun, frame_err
   );
endinterface

`default_nettype wire

// File: rtl/tty_sync_fifo.sv
// tty_sync_fifo: small synchronous FIFO with extra-bit pointers and synchronous flush.
// Rev 1.0
`default_nettype none

module tty_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge CLK) begin
      if (!RESET || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/tty_rx_buffer.sv
// tty_rx_buffer: 8N1 console keyboard receiver with FIFO feeding the keyboard IOT logic.
// Rev 1.0
`default_nettype none

module tty_rx_buffer
   import pdp8_tty_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4,
   parameter int FORCE_BIT7 = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   tty_rx_buffer_if.slave   bus
);

   localparam int          DIV      = calc_div(CLK_HZ, BAUD);
   localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
   localparam logic [3:0]  TC_MID   = 4'(MID_TICK);
   localparam logic [3:0]  TC_LAST  = 4'(OVERSAMPLE - 1);
   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  sync;
   logic        rx_s;
   logic [15:0] div_cnt;
   logic        tick;
   rx_state_t   state;
   rx_state_t   state_d;
   logic [3:0]  tc;
   logic [2:0]  idx;
   logic [7:0]  shift;
   logic        push;
   logic        frame_set;
   logic [7:0]  rx_byte;
   logic [7:0]  head;
   logic        full;
   logic        empty;
   logic [CW-1:0] fifo_count;
   logic        overrun;
   logic        frame_err;

   always_ff @(posedge CLK) begin
      if (!RESET) sync <= 2'b11;
      else        sync <= {sync[0], bus.rx};
   end
   assign rx_s = sync[1];

   always_ff @(posedge CLK) begin
      if (!RESET || div_cnt == DIV_LAST) div_cnt <= '0;
      else                               div_cnt <= div_cnt + 16'd1;
   end
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge CLK) begin
      if (!RESET || bus.clear) begin
         state <= IDLE;
         tc    <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_d;
         if (tick) begin
            if (state == IDLE || state != state_d) tc <= '0;
            else                                   tc <= tc + 4'd1;
            if (state == START) idx <= '0;
            if (state == DATA && tc == TC_LAST) begin
               shift[idx] <= rx_s;
               idx        <= idx + 3'd1;
            end
         end
      end
   end

   always_comb begin
      state_d = state;
      if (tick) begin
         case (state)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (tc == TC_MID) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tc == TC_LAST && idx == 3'd7) state_d = STOP;
            STOP:    if (tc == TC_LAST) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Stop bit is judged at its middle, the 16th tick after the last data sample.
   always_comb begin
      push      = 1'b0;
      frame_set = 1'b0;
      if (tick && state == STOP && tc == TC_LAST) begin
         push      = rx_s;
         frame_set = ~rx_s;
      end
   end

   assign rx_byte = {(FORCE_BIT7 != 0) ? 1'b1 : shift[7], shift[6:0]};

   tty_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (bus.clear),
      .push  (push),
      .pop   (bus.pop),
      .wdata (rx_byte),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge CLK) begin
      if (!RESET || bus.clear) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push && full && !bus.pop) overrun <= 1'b1;
         if (frame_set)                frame_err <= 1'b1;
      end
   end

   assign bus.data      = empty ? 8'h00 : head;
   assign bus.avail     = ~empty;
   assign bus.irq       = ~empty;
   assign bus.count     = 5'(fifo_count);
   assign bus.overrun   = overrun;
   assign bus.frame_err = frame_err;

endmodule

`default_nettype wire

// File: tb/tb_tty_rx_buffer.sv
// tb_tty_rx_buffer: directed self-checking bench for tty_rx_buffer at 16 clocks per bit.
// Rev 1.0
`default_nettype none

module tb_tty_rx_buffer;
   import pdp8_tty_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   tty_rx_buffer_if bus ();

   tty_rx_buffer #(
      .CLK_HZ     (1600000),
      .BAUD       (100000),
      .FIFO_DEPTH (4),
      .FORCE_BIT7 (1)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   // One 10-bit frame, one bit per 16 clocks. abort_kind 1 = reset, 2 = clear, at cycle abort_cyc.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_cyc,
                             input int abort_kind, input bit pop_on_push,
                             output int avail_cyc, output int pops);
      logic [9:0] frame;
      frame     = {stop_bit, b, 1'b0};
      avail_cyc = -1;
      pops      = 0;
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         if (avail_cyc < 0 && bus.avail) avail_cyc = c;
         if (c == abort_cyc) begin
            if (abort_kind == 1) rst_n = 1'b0;
            else                 bus.clear = 1'b1;
            bus.rx = 1'b1;
            @(negedge clk);
            rst_n     = 1'b1;
            bus.clear = 1'b0;
            break;
         end
         bus.rx  = frame[c / 16];
         bus.pop = pop_on_push && dut.push;
         if (bus.pop) pops++;
      end
      @(negedge clk);
      bus.rx  = 1'b1;
      bus.pop = 1'b0;
   endtask

   initial begin
      int av;
      int np;
      n_checks  = 0;
      n_errors  = 0;
      bus.rx    = 1'b1;
      bus.clear = 1'b0;
      bus.pop   = 1'b0;
      rst_n     = 1'b0;
      idle(3);
      check_eq("rst_avail", 32'(bus.avail), 32'd0);
      check_eq("rst_data", 32'(bus.data), 32'h00);
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_irq", 32'(bus.irq), 32'd0);
      check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
      check_eq("rst_frame", 32'(bus.frame_err), 32'd0);
      rst_n = 1'b1;
      idle(5);

      // 1: single byte, forced bit 7, latency bound, pop
      send_frame(8'h41, 1'b1, -1, 0, 1'b0, av, np);
      check_eq("t1_latency_ok", 32'(av >= 0 && av <= 156), 32'd1);
      check_eq("t1_data", 32'(bus.data), 32'hC1);
      check_eq("t1_count", 32'(bus.count), 32'd1);
      check_eq("t1_irq", 32'(bus.irq), 32'd1);
      pop_one();
      check_eq("t1_avail_after_pop", 32'(bus.avail), 32'd0);
      check_eq("t1_count_after_pop", 32'(bus.count), 32'd0);

      // 2: 4-clock glitch rejected
      @(negedge clk);
      bus.rx = 1'b0;
      idle(4);
      bus.rx = 1'b1;
      idle(30);
      check_eq("t2_avail", 32'(bus.avail), 32'd0);
      check_eq("t2_frame", 32'(bus.frame_err), 32'd0);
      check_eq("t2_state", 32'(dut.state), 32'(IDLE));

      // 3: framing error, then a good byte
      send_frame(8'h7F, 1'b0, -1, 0, 1'b0, av, np);
      idle(30);
      check_eq("t3_frame", 32'(bus.frame_err), 32'd1);
      check_eq("t3_count", 32'(bus.count), 32'd0);
      send_frame(8'h0D, 1'b1, -1, 0, 1'b0, av, np);
      check_eq("t3_data", 32'(bus.data), 32'h8D);
      check_eq("t3_frame_sticky", 32'(bus.frame_err), 32'd1);
      pop_one();

      // 4: overrun on fifth byte
      pulse_clear();
      check_eq("t4_clear_frame", 32'(bus.frame_err), 32'd0);
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, 0, 1'b0, av, np);
      check_eq("t4_count", 32'(bus.count), 32'd4);
      check_eq("t4_overrun", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t4_pop%0d", i), 32'(bus.data), 32'(8'h81 + i));
         pop_one();
      end
      check_eq("t4_empty", 32'(bus.avail), 32'd0);
      check_eq("t4_overrun_sticky", 32'(bus.overrun), 32'd1);

      // 5: push and pop on the same cycle while full
      pulse_clear();
      for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 1'b1, -1, 0, 1'b0, av, np);
      check_eq("t5_full", 32'(bus.count), 32'd4);
      send_frame(8'h55, 1'b1, -1, 0, 1'b1, av, np);
      check_eq("t5_pop_pulses", 32'(np), 32'd1);
      check_eq("t5_count", 32'(bus.count), 32'd4);
      check_eq("t5_overrun", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("t5_pop%0d", i), 32'(bus.data), 32'(8'h91 + i));
         pop_one();
      end
      check_eq("t5_tail", 32'(bus.data), 32'hD5);
      pop_one();

      // 6: reset, then clear, in the middle of bit 4
      for (int k = 1; k <= 2; k++) begin
         send_frame(8'h22, 1'b1, -1, 0, 1'b0, av, np);
         send_frame(8'h7F, 1'b0, -1, 0, 1'b0, av, np);
         idle(30);
         check_eq($sformatf("t6_pre_frame_%0d", k), 32'(bus.frame_err), 32'd1);
         send_frame(8'h31, 1'b1, 88, k, 1'b0, av, np);
         check_eq($sformatf("t6_avail_%0d", k), 32'(bus.avail), 32'd0);
         check_eq($sformatf("t6_data_%0d", k), 32'(bus.data), 32'h00);
         check_eq($sformatf("t6_count_%0d", k), 32'(bus.count), 32'd0);
         check_eq($sformatf("t6_irq_%0d", k), 32'(bus.irq), 32'd0);
         check_eq($sformatf("t6_frame_%0d", k), 32'(bus.frame_err), 32'd0);
         check_eq($sformatf("t6_overrun_%0d", k), 32'(bus.overrun), 32'd0);
         check_eq($sformatf("t6_state_%0d", k), 32'(dut.state), 32'(IDLE));
         idle(20);
         send_frame(8'h31, 1'b1, -1, 0, 1'b0, av, np);
         check_eq($sformatf("t6_next_data_%0d", k), 32'(bus.data), 32'hB1);
         check_eq($sformatf("t6_next_count_%0d", k), 32'(bus.count), 32'd1);
         pop_one();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
